wb_pipe_unit: RTL and testbench

WB_PIPE_UNIT -- requirements
Module: wb_pipe_unit

---
 rtl/wb_pipe_unit.sv | 118 +++++++++++
 tb/tb_wb_pipe_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_unit.sv
// Single-entry write-back stage: selects and load-aligns the write-back value,
// holds it for one register-file write, forwards it, and counts retirements.
module wb_pipe_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] in_reg_waddr,
  input  logic [1:0]                in_wb_sel,
  input  logic [DATA_WIDTH-1:0]     in_pc4,
  input  logic [DATA_WIDTH-1:0]     in_alu,
  input  logic [DATA_WIDTH-1:0]     in_mem,
  input  logic [DATA_WIDTH-1:0]     in_csr,
  input  logic [1:0]                in_ld_size,
  input  logic                      in_ld_unsigned,
  input  logic [2:0]                in_ld_off,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      in_ready,
  output logic                      reg_wen,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      misalign,
  output logic [CNT_WIDTH-1:0]      retire_cnt
);

  localparam int OFF_W = (DATA_WIDTH == 64) ? 3 : 2;

  typedef struct packed {
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  logic                  held_valid;
  entry_t                held;
  logic [1:0]            size;
  logic [OFF_W-1:0]      off;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_val;
  logic [DATA_WIDTH-1:0] wb_val;
  logic                  is_mem;
  logic                  mis;
  logic                  accept;
  logic                  commit;

  // A 32-bit datapath has no dword: size 3 degrades to word, off[2] drops out.
  assign size    = (DATA_WIDTH == 32 && in_ld_size == 2'd3) ? 2'd2 : in_ld_size;
  assign off     = in_ld_off[OFF_W-1:0];
  assign shifted = in_mem >> {off, 3'b000};
  assign is_mem  = (in_wb_sel == 2'd2);
  assign mis     = ((size == 2'd1) && in_ld_off[0])
                || ((size == 2'd2) && (|in_ld_off[1:0]))
                || ((size == 2'd3) && (|in_ld_off));

  always_comb begin
    ld_val = shifted;
    case (size)
      2'd0: ld_val = in_ld_unsigned ? DATA_WIDTH'(shifted[7:0])
                                    : DATA_WIDTH'($signed(shifted[7:0]));
      2'd1: ld_val = in_ld_unsigned ? DATA_WIDTH'(shifted[15:0])
                                    : DATA_WIDTH'($signed(shifted[15:0]));
      2'd2: ld_val = in_ld_unsigned ? DATA_WIDTH'(shifted[31:0])
                                    : DATA_WIDTH'($signed(shifted[31:0]));
      default: ld_val = shifted;
    endcase
  end

  always_comb begin
    wb_val = in_alu;
    case (in_wb_sel)
      2'd0: wb_val = in_pc4;
      2'd1: wb_val = in_alu;
      2'd2: wb_val = ld_val;
      default: wb_val = in_csr;
    endcase
  end

  // Flush wins over both the pending commit and a same-edge acceptance.
  assign in_ready = !held_valid || !stall;
  assign accept   = in_valid && in_ready && !flush;
  assign commit   = held_valid && !stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid <= 1'b0;
      held       <= '0;
      misalign   <= 1'b0;
      retire_cnt <= '0;
    end else begin
      misalign <= accept && is_mem && mis;
      if (commit) retire_cnt <= retire_cnt + CNT_WIDTH'(1);
      if (accept) begin
        held_valid <= 1'b1;
        held.wen   <= in_reg_wen && !(is_mem && mis);
        held.addr  <= in_reg_waddr;
        held.data  <= wb_val;
      end else if (commit || flush) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign fwd_valid = held_valid && held.wen && (held.addr != '0);
  assign fwd_addr  = held.addr;
  assign fwd_data  = held.data;
  assign reg_wen   = commit && held.wen && (held.addr != '0);
  assign reg_waddr = held_valid ? held.addr : '0;
  assign reg_wdata = held_valid ? held.data : '0;

endmodule

// File: tb/tb_wb_pipe_unit.sv
// Bench for wb_pipe_unit: directed literal checks followed by random traffic,
// with a behavioural model checked against every output each cycle.
module tb_wb_pipe_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_reg_wen, in_ld_unsigned, stall, flush;
  logic [AW-1:0] in_reg_waddr;
  logic [1:0]    in_wb_sel, in_ld_size;
  logic [DW-1:0] in_pc4, in_alu, in_mem, in_csr;
  logic [2:0]    in_ld_off;
  logic          in_ready, reg_wen, fwd_valid, misalign;
  logic [AW-1:0] reg_waddr, fwd_addr;
  logic [DW-1:0] reg_wdata, fwd_data;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  wb_pipe_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_reg_wen(in_reg_wen),
    .in_reg_waddr(in_reg_waddr), .in_wb_sel(in_wb_sel), .in_pc4(in_pc4),
    .in_alu(in_alu), .in_mem(in_mem), .in_csr(in_csr), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_ld_off(in_ld_off), .stall(stall),
    .flush(flush), .in_ready(in_ready), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .misalign(misalign), .retire_cnt(retire_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // model state: the one held entry plus the retire count
  bit            mv, mwen, mmis;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  int            mcnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit exp_mis(input logic [1:0] size, input logic [2:0] off);
    return ((int'(off) % 4) % nbytes(size)) != 0;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic [1:0] sel, input logic [DW-1:0] pc4,
      input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] csr,
      input logic [1:0] size, input bit uns, input logic [2:0] off);
    longint v;
    int     nb;
    case (sel)
      2'd0: return pc4;
      2'd1: return alu;
      2'd3: return csr;
      default: ;
    endcase
    nb = nbytes(size);
    v  = (longint'(mem) >> (8 * (int'(off) % 4))) % (longint'(1) << (8 * nb));
    if (!uns && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  always @(posedge clk) begin
    bit commit, acc, bad;
    if (rst) begin
      mv = 0; mmis = 0; mcnt = 0;
    end else begin
      commit = mv && !stall && !flush;
      acc    = in_valid && (!mv || !stall) && !flush;
      mmis   = 0;
      if (commit) mcnt = (mcnt + 1) % (1 << CW);
      if (acc) begin
        bad   = (in_wb_sel == 2'd2) && exp_mis(in_ld_size, in_ld_off);
        mv    = 1;
        mwen  = in_reg_wen && !bad;
        maddr = in_reg_waddr;
        mdata = exp_data(in_wb_sel, in_pc4, in_alu, in_mem, in_csr,
                         in_ld_size, in_ld_unsigned, in_ld_off);
        mmis  = bad;
      end else if (commit || flush) begin
        mv = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk); #3;
    if (chk_on) begin
      chk("in_ready",  in_ready,  !mv || !stall);
      chk("reg_wen",   reg_wen,   mv && mwen && maddr != 0 && !stall && !flush);
      chk("reg_waddr", reg_waddr, mv ? maddr : '0);
      chk("reg_wdata", reg_wdata, mv ? mdata : '0);
      chk("fwd_valid", fwd_valid, mv && mwen && maddr != 0);
      if (mv) begin
        chk("fwd_addr", fwd_addr, maddr);
        chk("fwd_data", fwd_data, mdata);
      end
      chk("misalign",   misalign,   mmis);
      chk("retire_cnt", retire_cnt, mcnt);
    end
  end

  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic set_entry(input logic [AW-1:0] addr, input logic [1:0] sel,
      input logic [DW-1:0] val, input logic [1:0] size, input bit uns, input logic [2:0] off);
    in_valid = 1; in_reg_wen = 1; in_reg_waddr = addr; in_wb_sel = sel;
    in_pc4 = val; in_alu = val; in_mem = val; in_csr = val;
    in_ld_size = size; in_ld_unsigned = uns; in_ld_off = off;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    set_entry('0, 2'd0, '0, 2'd2, 0, 3'd0);
    in_valid = 0;
    repeat (2) @(posedge clk);
    tick;
    chk_on = 1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_misalign", misalign, 0);
    rst = 0;

    // ALU write
    set_entry(5, 2'd1, 32'h1234, 2'd2, 0, 3'd0);
    tick; in_valid = 0; #1;
    chk("alu_wen", reg_wen, 1);
    chk("alu_waddr", reg_waddr, 5);
    chk("alu_wdata", reg_wdata, 32'h0000_1234);
    chk("alu_cnt0", retire_cnt, 0);
    tick;
    chk("alu_cnt1", retire_cnt, 1);

    // byte load from offset 3, signed then unsigned, back to back
    set_entry(3, 2'd2, 32'h80FF_7F01, 2'd0, 0, 3'd3);
    tick;
    set_entry(3, 2'd2, 32'h80FF_7F01, 2'd0, 1, 3'd3); #1;
    chk("lb_signed", reg_wdata, 32'hFFFF_FF80);
    tick; in_valid = 0; #1;
    chk("lb_unsigned", reg_wdata, 32'h0000_0080);
    chk("lb_wen", reg_wen, 1);
    tick;
    chk("lb_cnt", retire_cnt, 3);

    // misaligned half
    set_entry(4, 2'd2, 32'h1234_5678, 2'd1, 0, 3'd1);
    tick; in_valid = 0; #1;
    chk("mis_pulse", misalign, 1);
    chk("mis_wen", reg_wen, 0);
    tick;
    chk("mis_drop", misalign, 0);
    chk("mis_cnt", retire_cnt, 4);

    // x0 destination
    set_entry(0, 2'd0, 32'h100, 2'd2, 0, 3'd0);
    tick; in_valid = 0; #1;
    chk("x0_wen", reg_wen, 0);
    chk("x0_fwd", fwd_valid, 0);
    tick;
    chk("x0_cnt", retire_cnt, 5);

    // three stalled cycles with the next entry waiting
    set_entry(7, 2'd1, 32'hAAAA, 2'd2, 0, 3'd0);
    tick;
    set_entry(8, 2'd1, 32'hBBBB, 2'd2, 0, 3'd0); stall = 1; #1;
    repeat (3) begin
      chk("stall_ready", in_ready, 0);
      chk("stall_wen", reg_wen, 0);
      chk("stall_fwd", fwd_data, 32'hAAAA);
      tick;
    end
    stall = 0; #1;
    chk("unstall_wen", reg_wen, 1);
    chk("unstall_data", reg_wdata, 32'hAAAA);
    tick; in_valid = 0; #1;
    chk("next_wen", reg_wen, 1);
    chk("next_addr", reg_waddr, 8);
    chk("next_data", reg_wdata, 32'hBBBB);
    tick;
    chk("stall_cnt", retire_cnt, 7);

    // flush drops the held entry
    set_entry(9, 2'd1, 32'hCCCC, 2'd2, 0, 3'd0);
    tick; in_valid = 0; flush = 1; #1;
    chk("flush_wen", reg_wen, 0);
    tick; flush = 0; #1;
    chk("flush_fwd", fwd_valid, 0);
    chk("flush_cnt", retire_cnt, 7);

    // run the counter up to all-ones, then wrap
    set_entry(1, 2'd0, 32'h4, 2'd2, 0, 3'd0);
    repeat (248) tick;
    in_valid = 0;
    tick;
    chk("cnt_max", retire_cnt, 8'hFF);
    in_valid = 1;
    tick; in_valid = 0;
    tick;
    chk("cnt_wrap", retire_cnt, 0);

    // reset while stalled
    set_entry(10, 2'd1, 32'hDDDD, 2'd2, 0, 3'd0);
    tick; in_valid = 0; stall = 1; rst = 1;
    tick; rst = 0; stall = 0; #1;
    chk("rst_stall_fwd", fwd_valid, 0);
    chk("rst_stall_wen", reg_wen, 0);
    chk("rst_stall_ready", in_ready, 1);

    repeat (3000) begin
      in_valid       = $urandom_range(0, 3) != 0;
      in_reg_wen     = $urandom_range(0, 7) != 0;
      in_reg_waddr   = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      in_wb_sel      = 2'($urandom);
      in_pc4         = $urandom;
      in_alu         = $urandom;
      in_mem         = $urandom;
      in_csr         = $urandom;
      in_ld_size     = 2'($urandom);
      in_ld_unsigned = 1'($urandom);
      in_ld_off      = 3'($urandom);
      stall          = $urandom_range(0, 3) == 0;
      flush          = $urandom_range(0, 15) == 0;
      rst            = $urandom_range(0, 63) == 0;
      tick;
    end
    in_valid = 0; stall = 0; flush = 0; rst = 0;
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
